// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Bit-serial MIPS multiply/divide unit with HI/LO registers.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_fix  = 2'd2;

  localparam logic [2:0] c_op_mthi = 3'd4;
  localparam logic [2:0] c_op_mtlo = 3'd5;

  logic [1:0]         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               muldiv_req;
  logic               accept;
  logic               op_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // A new MULT/DIV may also be taken on the FIX edge so that ops chain with no idle gap.
  assign muldiv_req = start & ~op[2];
  assign accept     = muldiv_req & ((state_q == c_st_idle) | (state_q == c_st_fix));

  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & rs_data[WIDTH-1];
  assign rt_neg    = op_signed & rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign rt_mag    = rt_neg ? (~rt_data + 1'b1) : rt_data;

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // Restoring step: remainder lives in acc_q upper half, quotient fills the lower half.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], mcand_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mplier_q};
  assign div_fit   = ~div_diff[WIDTH];
  assign div_rem   = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = div0_q ? {WIDTH{1'b1}}
                  : (neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
  assign rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (accept) state_d = c_st_calc;
      c_st_calc: if (cnt_q == c_cnt_last) state_d = c_st_fix;
      c_st_fix:  state_d = accept ? c_st_calc : c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  always_comb begin
    busy_d = (state_d != c_st_idle);
    done_d = (state_q == c_st_fix);
  end

  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q == c_st_calc) begin
      cnt_d   = cnt_q + 1'b1;
      mcand_d = mcand_q << 1;
      if (is_div_q) begin
        acc_d = {div_rem, acc_q[WIDTH-2:0], div_fit};
      end else begin
        acc_d    = mul_sum;
        mplier_d = mplier_q >> 1;
      end
    end

    if (state_q == c_st_fix) begin
      if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end

    if (accept) begin
      cnt_d     = '0;
      is_div_d  = op[1];
      neg_d     = rs_neg ^ rt_neg;
      rem_neg_d = rs_neg;
      div0_d    = (rt_data == '0);
      mcand_d   = {{WIDTH{1'b0}}, rs_mag};
      mplier_d  = rt_mag;
      acc_d     = '0;
    end else if (start && (state_q == c_st_idle)) begin
      if (op == c_op_mthi) hi_d = rs_data;
      if (op == c_op_mtlo) lo_d = rs_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit with an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  bit          in_fix = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS divide-by-zero convention.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_model = '0;
    case (o)
      3'd0: ref_model = sa * sb;
      3'd1: ref_model = ua * ub;
      3'd2: begin
        if (b == 32'd0) ref_model = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          ref_model = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) ref_model = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          ref_model = {ur[31:0], uq[31:0]};
        end
      end
      default: ref_model = '0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($urandom_range(0, 20));
      1: v = -32'($urandom_range(1, 20));
      2: begin
        case ($urandom_range(0, 3))
          0: v = 32'h00000000;
          1: v = 32'h80000000;
          2: v = 32'hFFFFFFFF;
          default: v = 32'h00000001;
        endcase
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_hi", hi, mon_e.hi);
        chk("result_lo", lo, mon_e.lo);
        chk("done_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic go_idle();
    if (in_fix) begin
      @(negedge clk);
      chk("busy_after_fix", {31'd0, busy}, 32'd0);
      in_fix = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    prev_hi = model_hi;
    prev_lo = model_lo;
    e.hi  = eh;
    e.lo  = el;
    e.due = cyc + 34;
    sb_q.push_back(e);
    model_hi = eh;
    model_lo = el;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    chk("busy_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el);
    launch(o, a, b, eh, el);
    repeat (15) @(negedge clk);
    chk("hold_hi", hi, prev_hi);
    chk("hold_lo", lo, prev_lo);
    repeat (17) @(negedge clk);
    in_fix = 1'b1;
  endtask

  task automatic run_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = ref_model(o, a, b);
    run_muldiv(o, a, b, r[63:32], r[31:0]);
  endtask

  task automatic issue_mt(input logic [2:0] o, input logic [31:0] a);
    go_idle();
    start   = 1'b1;
    op      = o;
    rs_data = a;
    if (o == 3'd4) model_hi = a;
    else if (o == 3'd5) model_lo = a;
    @(negedge clk);
    start = 1'b0;
    chk("mt_busy", {31'd0, busy}, 32'd0);
    chk("mt_hi", hi, model_hi);
    chk("mt_lo", lo, model_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;

    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    rs_data = '0;
    rt_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue_mt(3'd4, 32'hDEADBEEF);
    issue_mt(3'd5, 32'hCAFEF00D);

    // Directed ops, each accepted on the previous op's FIX edge.
    run_muldiv(3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_muldiv(3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA);
    run_muldiv(3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_muldiv(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_muldiv(3'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
    run_muldiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI raised mid-CALC must be dropped.
    launch(3'd0, 32'd7, 32'd9, 32'd0, 32'd63);
    repeat (5) @(negedge clk);
    start   = 1'b1;
    op      = 3'd4;
    rs_data = 32'h55555555;
    @(negedge clk);
    start = 1'b0;
    chk("mt_in_calc_hi", hi, prev_hi);
    chk("mt_in_calc_lo", lo, prev_lo);
    repeat (26) @(negedge clk);
    in_fix = 1'b1;

    issue_mt(3'd6, 32'h11111111);
    issue_mt(3'd7, 32'h22222222);

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      if (o < 3'd4) run_model(o, a, b);
      else issue_mt(o, a);
    end

    // Reset in the middle of CALC discards the op.
    issue_mt(3'd4, 32'h13579BDF);
    issue_mt(3'd5, 32'h2468ACE0);
    launch(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    sb_q.delete();
    model_hi = '0;
    model_lo = '0;
    in_fix   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_hi", hi, 32'd0);
    chk("post_reset_lo", lo, 32'd0);

    // Random ops after reset, then drain.
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 3));
      run_model(o, rnd_operand(), rnd_operand());
    end
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
